// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
package mem_arbiter_pkg;

  // LSU access size encodings; 2'b11 is reserved and handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Latency counter width, wide enough for LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_align_chk.sv
// Combinational misalignment detector. Fetches are always words; LSU
// accesses are checked against their size, reserved size counts as word.
module mem_arbiter_align_chk
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lsb,
  input  logic       is_fetch,
  output logic       err
);

  // Flag any address that does not sit on its natural boundary.
  always_comb begin
    err = 1'b0;
    if (is_fetch) begin
      err = |addr_lsb;
    end else begin
      case (size)
        SZ_BYTE: err = 1'b0;
        SZ_HALF: err = addr_lsb[0];
        default: err = |addr_lsb;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction fetch unit and the
// load/store unit. LSU has fixed priority, one transaction is in flight at
// a time, and the memory enable fires after LATENCY cycles in ACCESS.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_req_valid,
  output logic             ifu_req_ready,
  input  logic [WIDTH-1:0] ifu_addr,
  output logic             ifu_rsp_valid,
  input  logic             ifu_rsp_ready,
  output logic [WIDTH-1:0] ifu_rdata,
  output logic             ifu_err,
  input  logic             lsu_req_valid,
  output logic             lsu_req_ready,
  input  logic             lsu_wen,
  input  logic [1:0]       lsu_size,
  input  logic [WIDTH-1:0] lsu_addr,
  input  logic [WIDTH-1:0] lsu_wdata,
  output logic             lsu_rsp_valid,
  input  logic             lsu_rsp_ready,
  output logic [WIDTH-1:0] lsu_rdata,
  output logic             lsu_err,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             mem_half_write,
  output logic             mem_byte_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  output logic [15:0]      mem_half_data,
  output logic [7:0]       mem_byte_data,
  input  logic [WIDTH-1:0] mem_read_data
);

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic             wen_q;
  logic [1:0]       size_q;
  // Held low while in reset so no requester sees a grant before the
  // arbiter is actually running.
  logic             live;

  logic             sel_lsu;
  logic             take;
  logic             req_wen;
  logic [1:0]       req_size;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             req_err;
  logic             rsp_done;

  assign lsu_req_ready = live & (state == ST_IDLE) & lsu_req_valid;
  assign ifu_req_ready = live & (state == ST_IDLE) & ifu_req_valid & ~lsu_req_valid;
  assign take          = lsu_req_ready | ifu_req_ready;

  assign ifu_rsp_valid = (state == ST_RESP) & (owner == OWN_IFU);
  assign lsu_rsp_valid = (state == ST_RESP) & (owner == OWN_LSU);
  assign rsp_done      = (owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  // Select the request that would win the grant this cycle.
  always_comb begin
    sel_lsu   = lsu_req_valid;
    req_wen   = sel_lsu & lsu_wen;
    req_size  = sel_lsu ? lsu_size : SZ_WORD;
    req_addr  = sel_lsu ? lsu_addr : ifu_addr;
    req_wdata = sel_lsu ? lsu_wdata : '0;
  end

  mem_arbiter_align_chk u_align_chk (
    .size     (req_size),
    .addr_lsb (req_addr[1:0]),
    .is_fetch (~sel_lsu),
    .err      (req_err)
  );

  // Arbitration FSM with registered memory-port and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      owner          <= OWN_IFU;
      cnt            <= '0;
      wen_q          <= 1'b0;
      size_q         <= SZ_WORD;
      live           <= 1'b0;
      ifu_rdata      <= '0;
      ifu_err        <= 1'b0;
      lsu_rdata      <= '0;
      lsu_err        <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_half_write <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_half_data  <= '0;
      mem_byte_data  <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (take) begin
            owner  <= sel_lsu ? OWN_LSU : OWN_IFU;
            wen_q  <= req_wen;
            size_q <= req_size;
            if (req_err) begin
              // Misaligned: answer immediately, memory is never touched.
              state <= ST_RESP;
              if (sel_lsu) begin
                lsu_rdata <= '0;
                lsu_err   <= 1'b1;
              end else begin
                ifu_rdata <= '0;
                ifu_err   <= 1'b1;
              end
            end else begin
              state          <= ST_ACCESS;
              cnt            <= CNT_W'(LATENCY - 1);
              mem_address    <= req_addr;
              mem_write_data <= req_wdata;
              mem_half_data  <= req_wdata[15:0];
              mem_byte_data  <= req_wdata[7:0];
              // With a single-cycle latency the first ACCESS cycle is
              // also the enable cycle.
              if (LATENCY == 1) begin
                mem_read_en    <= ~req_wen;
                mem_write_en   <= req_wen;
                mem_half_write <= req_wen & (req_size == SZ_HALF);
                mem_byte_write <= req_wen & (req_size == SZ_BYTE);
              end
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state          <= ST_RESP;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_half_write <= 1'b0;
            mem_byte_write <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_half_data  <= '0;
            mem_byte_data  <= '0;
            if (owner == OWN_LSU) begin
              lsu_rdata <= wen_q ? '0 : mem_read_data;
              lsu_err   <= 1'b0;
            end else begin
              ifu_rdata <= mem_read_data;
              ifu_err   <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
            // Arm the enables so they are high exactly when cnt reaches 0.
            if (cnt == CNT_W'(1)) begin
              mem_read_en    <= ~wen_q;
              mem_write_en   <= wen_q;
              mem_half_write <= wen_q & (size_q == SZ_HALF);
              mem_byte_write <= wen_q & (size_q == SZ_BYTE);
            end
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut_a runs with LATENCY = 1 against a small word memory,
// dut_b runs with LATENCY = 4 against an address-derived read pattern.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_ifu_req_valid, a_ifu_req_ready, a_ifu_rsp_valid, a_ifu_rsp_ready, a_ifu_err;
  logic [31:0] a_ifu_addr, a_ifu_rdata;
  logic        a_lsu_req_valid, a_lsu_req_ready, a_lsu_wen, a_lsu_rsp_valid, a_lsu_rsp_ready, a_lsu_err;
  logic [1:0]  a_lsu_size;
  logic [31:0] a_lsu_addr, a_lsu_wdata, a_lsu_rdata;
  logic        a_mem_read_en, a_mem_write_en, a_mem_half_write, a_mem_byte_write;
  logic [31:0] a_mem_address, a_mem_write_data, a_mem_read_data;
  logic [15:0] a_mem_half_data;
  logic [7:0]  a_mem_byte_data;

  logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_rsp_valid, b_ifu_rsp_ready, b_ifu_err;
  logic [31:0] b_ifu_addr, b_ifu_rdata;
  logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen, b_lsu_rsp_valid, b_lsu_rsp_ready, b_lsu_err;
  logic [1:0]  b_lsu_size;
  logic [31:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
  logic        b_mem_read_en, b_mem_write_en, b_mem_half_write, b_mem_byte_write;
  logic [31:0] b_mem_address, b_mem_write_data, b_mem_read_data;
  logic [15:0] b_mem_half_data;
  logic [7:0]  b_mem_byte_data;

  mem_arbiter #(.WIDTH(32), .LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(a_ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(a_ifu_addr),
    .ifu_rsp_valid(a_ifu_rsp_valid), .ifu_rsp_ready(a_ifu_rsp_ready), .ifu_rdata(a_ifu_rdata),
    .ifu_err(a_ifu_err),
    .lsu_req_valid(a_lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_wen(a_lsu_wen),
    .lsu_size(a_lsu_size), .lsu_addr(a_lsu_addr), .lsu_wdata(a_lsu_wdata),
    .lsu_rsp_valid(a_lsu_rsp_valid), .lsu_rsp_ready(a_lsu_rsp_ready), .lsu_rdata(a_lsu_rdata),
    .lsu_err(a_lsu_err),
    .mem_read_en(a_mem_read_en), .mem_write_en(a_mem_write_en),
    .mem_half_write(a_mem_half_write), .mem_byte_write(a_mem_byte_write),
    .mem_address(a_mem_address), .mem_write_data(a_mem_write_data),
    .mem_half_data(a_mem_half_data), .mem_byte_data(a_mem_byte_data),
    .mem_read_data(a_mem_read_data)
  );

  mem_arbiter #(.WIDTH(32), .LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
    .ifu_rsp_valid(b_ifu_rsp_valid), .ifu_rsp_ready(b_ifu_rsp_ready), .ifu_rdata(b_ifu_rdata),
    .ifu_err(b_ifu_err),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_wen(b_lsu_wen),
    .lsu_size(b_lsu_size), .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata),
    .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rsp_ready(b_lsu_rsp_ready), .lsu_rdata(b_lsu_rdata),
    .lsu_err(b_lsu_err),
    .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en),
    .mem_half_write(b_mem_half_write), .mem_byte_write(b_mem_byte_write),
    .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
    .mem_half_data(b_mem_half_data), .mem_byte_data(b_mem_byte_data),
    .mem_read_data(b_mem_read_data)
  );

  // Word memory for dut_a: words 0..3 at 0x80000000, 4..7 at 0x80001000.
  logic [31:0] mem_a [0:7];
  logic [2:0]  a_idx;
  assign a_idx           = {a_mem_address[12], a_mem_address[3:2]};
  assign a_mem_read_data = mem_a[a_idx];
  assign b_mem_read_data = b_mem_address ^ 32'hA5A5_0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem_a[i] <= 32'h0;
      mem_a[0] <= 32'h0000_0413;
      mem_a[1] <= 32'h0000_0093;
      mem_a[4] <= 32'hDEAD_BEEF;
    end else if (a_mem_write_en) begin
      if (a_mem_byte_write)
        mem_a[a_idx][{a_mem_address[1:0], 3'b000} +: 8] <= a_mem_byte_data;
      else if (a_mem_half_write)
        mem_a[a_idx][{a_mem_address[1], 4'b0000} +: 16] <= a_mem_half_data;
      else
        mem_a[a_idx] <= a_mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_ifu_req_valid = 0; a_ifu_addr = 0; a_ifu_rsp_ready = 1;
    a_lsu_req_valid = 0; a_lsu_wen = 0; a_lsu_size = 2'b10; a_lsu_addr = 0; a_lsu_wdata = 0;
    a_lsu_rsp_ready = 1;
    b_ifu_req_valid = 0; b_ifu_addr = 0; b_ifu_rsp_ready = 1;
    b_lsu_req_valid = 0; b_lsu_wen = 0; b_lsu_size = 2'b10; b_lsu_addr = 0; b_lsu_wdata = 0;
    b_lsu_rsp_ready = 1;

    // Reset state
    tick;
    a_lsu_req_valid = 1; #1;
    chk("rst_lsu_ready", a_lsu_req_ready, 0);
    chk("rst_ifu_rsp_valid", a_ifu_rsp_valid, 0);
    chk("rst_lsu_rsp_valid", a_lsu_rsp_valid, 0);
    chk("rst_ifu_rdata", a_ifu_rdata, 0);
    chk("rst_lsu_rdata", a_lsu_rdata, 0);
    chk("rst_mem_read_en", a_mem_read_en, 0);
    chk("rst_mem_address", a_mem_address, 0);
    chk("rst_b_mem_write_en", b_mem_write_en, 0);
    a_lsu_req_valid = 0;
    tick;
    rst_n = 1'b1;
    tick; tick;

    // Aligned fetch, LATENCY = 1
    a_ifu_req_valid = 1; a_ifu_addr = 32'h8000_0000; #1;
    chk("t1_ifu_ready", a_ifu_req_ready, 1);
    chk("t1_lsu_ready", a_lsu_req_ready, 0);
    tick; a_ifu_req_valid = 0; #1;
    chk("t1_rd_en", a_mem_read_en, 1);
    chk("t1_mem_addr", a_mem_address, 32'h8000_0000);
    chk("t1_no_rsp_yet", a_ifu_rsp_valid, 0);
    tick; #1;
    chk("t1_rd_en_off", a_mem_read_en, 0);
    chk("t1_rsp_valid", a_ifu_rsp_valid, 1);
    chk("t1_rdata", a_ifu_rdata, 32'h0000_0413);
    chk("t1_err", a_ifu_err, 0);
    tick; #1;
    chk("t1_rsp_done", a_ifu_rsp_valid, 0);

    // Simultaneous requests: LSU first, IFU after the LSU response
    a_ifu_req_valid = 1; a_ifu_addr = 32'h8000_0004;
    a_lsu_req_valid = 1; a_lsu_wen = 0; a_lsu_size = 2'b10; a_lsu_addr = 32'h8000_1000; #1;
    chk("t2_lsu_ready", a_lsu_req_ready, 1);
    chk("t2_ifu_ready", a_ifu_req_ready, 0);
    tick; a_lsu_req_valid = 0; #1;
    chk("t2_ifu_wait_access", a_ifu_req_ready, 0);
    chk("t2_mem_addr", a_mem_address, 32'h8000_1000);
    tick; #1;
    chk("t2_lsu_rsp_valid", a_lsu_rsp_valid, 1);
    chk("t2_lsu_rdata", a_lsu_rdata, 32'hDEAD_BEEF);
    chk("t2_ifu_rsp_valid", a_ifu_rsp_valid, 0);
    chk("t2_ifu_wait_resp", a_ifu_req_ready, 0);
    tick; #1;
    chk("t2_ifu_granted", a_ifu_req_ready, 1);
    chk("t2_lsu_rsp_done", a_lsu_rsp_valid, 0);
    tick; a_ifu_req_valid = 0; #1;
    chk("t2_ifu_rd_en", a_mem_read_en, 1);
    tick; #1;
    chk("t2_ifu_rsp_valid", a_ifu_rsp_valid, 1);
    chk("t2_ifu_rdata", a_ifu_rdata, 32'h0000_0093);
    tick;

    // Byte store to the top byte lane, then read back the word
    a_lsu_req_valid = 1; a_lsu_wen = 1; a_lsu_size = 2'b00;
    a_lsu_addr = 32'h8000_1003; a_lsu_wdata = 32'h1234_56AB; #1;
    chk("t3_ready", a_lsu_req_ready, 1);
    tick; a_lsu_req_valid = 0; #1;
    chk("t3_wen", a_mem_write_en, 1);
    chk("t3_byte_write", a_mem_byte_write, 1);
    chk("t3_half_write", a_mem_half_write, 0);
    chk("t3_byte_data", a_mem_byte_data, 32'h0000_00AB);
    chk("t3_rd_en", a_mem_read_en, 0);
    tick; #1;
    chk("t3_wen_off", a_mem_write_en, 0);
    chk("t3_byte_off", a_mem_byte_write, 0);
    chk("t3_ack_valid", a_lsu_rsp_valid, 1);
    chk("t3_ack_rdata", a_lsu_rdata, 0);
    chk("t3_ack_err", a_lsu_err, 0);
    tick;
    a_lsu_req_valid = 1; a_lsu_wen = 0; a_lsu_size = 2'b10; a_lsu_addr = 32'h8000_1000; #1;
    tick; a_lsu_req_valid = 0;
    tick; #1;
    chk("t3_readback", a_lsu_rdata, 32'hABAD_BEEF);
    tick;

    // Misaligned half load and misaligned fetch
    a_lsu_req_valid = 1; a_lsu_size = 2'b01; a_lsu_addr = 32'h8000_1001; #1;
    chk("t4_rd_en_idle", a_mem_read_en, 0);
    tick; a_lsu_req_valid = 0; #1;
    chk("t4_rsp_valid", a_lsu_rsp_valid, 1);
    chk("t4_err", a_lsu_err, 1);
    chk("t4_rdata", a_lsu_rdata, 0);
    chk("t4_rd_en", a_mem_read_en, 0);
    chk("t4_mem_addr", a_mem_address, 0);
    tick; #1;
    chk("t4_done", a_lsu_rsp_valid, 0);
    a_ifu_req_valid = 1; a_ifu_addr = 32'h8000_0002; #1;
    tick; a_ifu_req_valid = 0; #1;
    chk("t4_ifu_err", a_ifu_err, 1);
    chk("t4_ifu_rdata", a_ifu_rdata, 0);
    chk("t4_ifu_rd_en", a_mem_read_en, 0);
    tick;

    // LATENCY = 4 load with response backpressure
    b_lsu_req_valid = 1; b_lsu_wen = 0; b_lsu_size = 2'b10; b_lsu_addr = 32'h8000_1000;
    b_lsu_rsp_ready = 0; #1;
    chk("t5_ready", b_lsu_req_ready, 1);
    tick; b_lsu_req_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("t5_rd_en", b_mem_read_en, (c == 4) ? 1 : 0);
      chk("t5_mem_addr", b_mem_address, 32'h8000_1000);
      chk("t5_no_rsp", b_lsu_rsp_valid, 0);
      tick;
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t5_rsp_valid", b_lsu_rsp_valid, 1);
      chk("t5_rdata", b_lsu_rdata, 32'h25A5_1000);
      chk("t5_rd_en_off", b_mem_read_en, 0);
      tick;
    end
    b_lsu_rsp_ready = 1; #1;
    chk("t5_rsp_still", b_lsu_rsp_valid, 1);
    tick; #1;
    chk("t5_rsp_done", b_lsu_rsp_valid, 0);
    b_lsu_req_valid = 1; #1;
    chk("t5_idle_ready", b_lsu_req_ready, 1);
    b_lsu_req_valid = 0;
    tick; #1;
    chk("t5_no_latch", b_mem_address, 0);

    // Reset in the middle of a LATENCY = 4 store
    b_lsu_req_valid = 1; b_lsu_wen = 1; b_lsu_size = 2'b10;
    b_lsu_addr = 32'h8000_1004; b_lsu_wdata = 32'hCAFE_F00D; #1;
    tick; b_lsu_req_valid = 0; #1;
    chk("t6_access_addr", b_mem_address, 32'h8000_1004);
    chk("t6_wen_c1", b_mem_write_en, 0);
    tick; #1;
    chk("t6_wen_c2", b_mem_write_en, 0);
    rst_n = 1'b0; #1;
    chk("t6_rst_addr", b_mem_address, 0);
    chk("t6_rst_wdata", b_mem_write_data, 0);
    chk("t6_rst_wen", b_mem_write_en, 0);
    chk("t6_rst_rsp", b_lsu_rsp_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("t6_in_rst_wen", b_mem_write_en, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk("t6_post_wen", b_mem_write_en, 0);
      chk("t6_post_rsp", b_lsu_rsp_valid, 0);
    end
    b_lsu_req_valid = 1; b_lsu_wen = 0; #1;
    chk("t6_idle_ready", b_lsu_req_ready, 1);
    b_lsu_req_valid = 0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
